// File: rtl/count_mon_pkg.sv
// Shared types for the dual-counter lock-step monitor and its event queue.
package count_mon_pkg;

  // Widest counter value an event payload can carry; narrower monitors zero-extend.
  localparam int unsigned EVT_VALUE_MAX = 32;

  typedef enum logic [1:0] {
    EVT_WRAP   = 2'b01,
    EVT_FAULT  = 2'b10,
    EVT_RESYNC = 2'b11
  } evt_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } mon_state_t;

  typedef struct packed {
    evt_code_t                code;
    logic [EVT_VALUE_MAX-1:0] value;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO: one push and one pop per cycle, head read from registered storage.
module evt_fifo
  import count_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  evt_t wdata_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output evt_t rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  evt_t          mem_q [DEPTH];
  logic          push_eff, pop_eff;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a full queue can still accept a push alongside it.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  // Next pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/count_pair_monitor.sv
// Lock-step checker for two counter instances: tracks q0 wraps, detects sustained
// disagreement (FAULT) and recovery (RESYNC), and queues those events for a host reader.
module count_pair_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MISMATCH_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             fault,
  output logic [7:0]       wrap_count,
  output logic             overflow
);

  localparam logic [3:0] Limit = 4'(MISMATCH_LIMIT);

  mon_state_t       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] prev_q0_q, prev_q0_d;
  logic [7:0]       wrap_count_q, wrap_count_d;
  logic             fault_q, fault_d;
  logic             overflow_q, overflow_d;

  logic       push, pop, full, empty, wrap_hit;
  logic [3:0] run_inc;
  evt_t       push_evt, head;
  logic       unused_head_value;

  assign run_inc  = run_q + 4'd1;
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign wrap_hit  = (state_q != IDLE) && en && (prev_q0_q == '1) && (q0 == '0);

  // FSM, run counter, wrap counter and event selection; FAULT/RESYNC wins the single push slot.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    prev_q0_d    = q0;
    wrap_count_d = wrap_count_q;
    push         = 1'b0;
    push_evt     = '{code: EVT_WRAP, value: '0};
    unique case (state_q)
      IDLE: state_d = TRACK;
      TRACK: begin
        if (q0 != q1) begin
          if (run_inc == Limit) begin
            state_d  = FAULT;
            run_d    = '0;
            push     = 1'b1;
            push_evt = '{code: EVT_FAULT, value: EVT_VALUE_MAX'(q0 ^ q1)};
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
        end
      end
      FAULT: begin
        if (q0 == q1) begin
          if (run_inc == Limit) begin
            state_d  = TRACK;
            run_d    = '0;
            push     = 1'b1;
            push_evt = '{code: EVT_RESYNC, value: EVT_VALUE_MAX'(q0)};
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wrap_hit) begin
      wrap_count_d = wrap_count_q + 8'd1;
      if (!push) begin
        push     = 1'b1;
        push_evt = '{code: EVT_WRAP, value: EVT_VALUE_MAX'(wrap_count_d)};
      end
    end
  end

  // Registered flags; a push into a full queue with no pop is lost and latches overflow.
  always_comb begin
    fault_d    = (state_d == FAULT);
    overflow_d = overflow_q | (push && full && !pop);
  end

  // Monitor state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run_q        <= '0;
      prev_q0_q    <= '0;
      wrap_count_q <= '0;
      fault_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q0_q    <= prev_q0_d;
      wrap_count_q <= wrap_count_d;
      fault_q      <= fault_d;
      overflow_q   <= overflow_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (push_evt),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .rdata_o (head)
  );

  // Payload bits above WIDTH are always zero.
  assign unused_head_value = ^head.value;

  assign evt_code   = evt_valid ? head.code : 2'b00;
  assign evt_value  = evt_valid ? head.value[WIDTH-1:0] : '0;
  assign fault      = fault_q;
  assign wrap_count = wrap_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_pair_monitor.sv
// Bench for count_pair_monitor: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based reference model.
module tb_count_pair_monitor;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LIM = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] q0 = '0;
  logic [W-1:0] q1 = '0;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_code;
  logic [W-1:0] evt_value;
  logic         fault;
  logic [7:0]   wrap_count;
  logic         overflow;

  always #5 clk = ~clk;

  count_pair_monitor #(
    .WIDTH          (W),
    .DEPTH          (D),
    .MISMATCH_LIMIT (LIM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .q0         (q0),
    .q1         (q1),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_value  (evt_value),
    .fault      (fault),
    .wrap_count (wrap_count),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   code;
    logic [W-1:0] value;
  } ev_s;

  // Reference model: mode 0 = waiting one cycle after reset, 1 = tracking, 2 = faulted.
  ev_s          mq[$];
  int           m_mode;
  int           m_run;
  int           m_wc;
  logic [W-1:0] m_prev;
  bit           m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_mode = 0;
    m_run  = 0;
    m_wc   = 0;
    m_prev = '0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_step(bit e, logic [W-1:0] a, logic [W-1:0] b, bit rdy);
    bit  pop, has, wrap, differ;
    ev_s ev;
    int  sz;
    sz   = mq.size();
    pop  = (sz > 0) && rdy;
    has  = 1'b0;
    ev   = '{2'b00, '0};
    if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      wrap   = e && (m_prev == {W{1'b1}}) && (a == '0);
      differ = (a != b);
      // Tracking counts disagreements, faulted counts agreements.
      if ((m_mode == 1) == differ) begin
        m_run++;
        if (m_run == LIM) begin
          m_run = 0;
          has   = 1'b1;
          if (m_mode == 1) begin
            m_mode = 2;
            ev     = '{2'b10, a ^ b};
          end else begin
            m_mode = 1;
            ev     = '{2'b11, a};
          end
        end
      end else begin
        m_run = 0;
      end
      if (wrap) begin
        m_wc = (m_wc + 1) % 256;
        if (!has) begin
          has = 1'b1;
          ev  = '{2'b01, W'(m_wc)};
        end
      end
    end
    m_prev = a;
    if (pop) void'(mq.pop_front());
    if (has) begin
      if (sz == D && !pop) m_ovf = 1'b1;
      else mq.push_back(ev);
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
    chk("fault", 32'(fault), 32'(m_mode == 2));
    chk("wrap_count", 32'(wrap_count), 32'(m_wc % 256));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("evt_code", 32'(evt_code), 32'(mq[0].code));
      chk("evt_value", 32'(evt_value), 32'(mq[0].value));
    end
  end

  task automatic cycle(input bit e, input logic [W-1:0] a, input logic [W-1:0] b, input bit rdy);
    en        = e;
    q0        = a;
    q1        = b;
    evt_ready = rdy;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step(e, a, b, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Three cycles of disagreement (odd=0) or agreement (odd=1) starting at value base.
  task automatic burst(input bit agree, input logic [W-1:0] base, input bit rdy_last);
    logic [W-1:0] v;
    for (int j = 0; j < LIM; j++) begin
      v = base + W'(j);
      cycle(1'b0, v, agree ? v : (v ^ 8'h5A), (j == LIM - 1) ? rdy_last : 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] cnt;
    model_reset();
    do_reset();

    // Lock-step count through one wrap with the reader always ready.
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, W'(i), W'(i), 1'b1);
      if (i == 256) begin
        chk("wrap_valid", 32'(evt_valid), 32'd1);
        chk("wrap_code", 32'(evt_code), 32'h1);
        chk("wrap_value", 32'(evt_value), 32'h1);
        chk("wrap_count_1", 32'(wrap_count), 32'd1);
        chk("wrap_no_fault", 32'(fault), 32'd0);
      end
    end

    // Sustained q1 = q0 + 1 raises FAULT; three agreeing cycles resync.
    cycle(1'b1, 8'd4, 8'd5, 1'b1);
    cycle(1'b1, 8'd5, 8'd6, 1'b1);
    cycle(1'b1, 8'd6, 8'd7, 1'b1);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_code", 32'(evt_code), 32'h2);
    chk("fault_value", 32'(evt_value), 32'h1);
    cycle(1'b1, 8'd7, 8'd7, 1'b1);
    cycle(1'b1, 8'd8, 8'd8, 1'b1);
    cycle(1'b1, 8'd9, 8'd9, 1'b1);
    chk("resync_fault_clr", 32'(fault), 32'd0);
    chk("resync_code", 32'(evt_code), 32'h3);
    chk("resync_value", 32'(evt_value), 32'h9);
    cycle(1'b1, 8'd10, 8'd10, 1'b1);

    // Six events against a stalled reader: four stored, the rest dropped.
    for (int k = 0; k < 6; k++) begin
      burst(k[0], W'(20 + 3 * k), 1'b0);
      if (k == 3) chk("ovf_after_4", 32'(overflow), 32'd0);
      if (k == 4) chk("ovf_after_5", 32'(overflow), 32'd1);
    end
    chk("drain_head_code", 32'(evt_code), 32'h2);
    chk("drain_head_value", 32'(evt_value), 32'h5A);
    for (int k = 0; k < 5; k++) cycle(1'b0, 8'd50, 8'd50, 1'b1);

    // Full queue with a simultaneous push and pop loses nothing.
    do_reset();
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) burst(k[0], W'(60 + 3 * k), 1'b0);
    burst(1'b0, 8'd80, 1'b1);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    chk("full_pushpop_valid", 32'(evt_valid), 32'd1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 8'd90, 8'd91, 1'b1);

    // FAULT threshold lands on the same cycle as a wrap.
    do_reset();
    cycle(1'b1, 8'd0, 8'd0, 1'b1);
    cycle(1'b1, 8'd254, 8'd1, 1'b1);
    cycle(1'b1, 8'd255, 8'd1, 1'b1);
    cycle(1'b1, 8'd0, 8'd1, 1'b1);
    chk("coll_wrap_count", 32'(wrap_count), 32'd1);
    chk("coll_fault", 32'(fault), 32'd1);
    chk("coll_code", 32'(evt_code), 32'h2);
    cycle(1'b1, 8'd1, 8'd1, 1'b1);
    chk("coll_no_wrap_evt", 32'(evt_valid), 32'd0);

    // Asynchronous reset mid-cycle with three events queued and fault high.
    do_reset();
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    burst(1'b0, 8'd30, 1'b0);
    burst(1'b1, 8'd40, 1'b0);
    burst(1'b0, 8'd50, 1'b0);
    chk("pre_rst_fault", 32'(fault), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_fault", 32'(fault), 32'd0);
    chk("async_rst_code", 32'(evt_code), 32'd0);
    chk("async_rst_value", 32'(evt_value), 32'd0);
    chk("async_rst_wraps", 32'(wrap_count), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(100 + i), W'(100 + i), 1'b0);
    chk("post_rst_quiet", 32'(evt_valid), 32'd0);

    // Random traffic: mostly-agreeing counters, frequent wraps, random reader.
    cnt = '0;
    for (int i = 0; i < 3000; i++) begin
      logic         e, rdy;
      logic [W-1:0] a, b;
      if (i % 1000 == 999) do_reset();
      if ($urandom_range(0, 40) == 0) cnt = 8'hFD;
      e   = ($urandom_range(0, 3) != 0);
      a   = cnt;
      b   = ($urandom_range(0, 9) < 7) ? a : W'($urandom);
      rdy = $urandom_range(0, 1) != 0;
      cycle(e, a, b, rdy);
      if (e) cnt = cnt + 8'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
